// File: rtl/banner_scroll_ctrl.sv
// Walks a WINDOW-row slice of the banner ROM, starting at a wrapping scroll offset,
// and hands each row downstream over valid/ready; the offset steps once per frame.
module banner_scroll_ctrl #(
  parameter int ROWS   = 129,
  parameter int WIDTH  = 57,
  parameter int WINDOW = 16,
  localparam int IDX_W = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             dir,
  output logic [7:0]       rom_address,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] col_data,
  output logic [IDX_W-1:0] col_index,
  output logic             col_valid,
  input  logic             col_ready,
  output logic             frame_done,
  output logic             overrun,
  output logic [7:0]       offset
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_rom_address;
  logic [WIDTH-1:0] r_col_data;
  logic [IDX_W-1:0] r_col_index;
  logic             r_col_valid;
  logic             r_frame_done;
  logic             r_overrun;
  logic [7:0]       r_offset;

  logic             w_hs;
  logic             w_last;
  logic [8:0]       w_addr_sum;
  logic [8:0]       w_addr_next;

  function automatic logic [7:0] f_next_offset(input logic [7:0] off, input logic d);
    if (d) return (off == 8'd0) ? 8'(ROWS - 1) : off - 8'd1;
    return (off == 8'(ROWS - 1)) ? 8'd0 : off + 8'd1;
  endfunction

  assign w_hs   = (r_state == SEND) && col_ready;
  assign w_last = (r_col_index == IDX_W'(WINDOW - 1));

  // Sum kept 9 bits wide so offset + index + 1 can exceed 255 before the wrap compare.
  assign w_addr_sum  = {1'b0, r_offset} + 9'(r_col_index) + 9'd1;
  assign w_addr_next = (w_addr_sum >= 9'(ROWS)) ? w_addr_sum - 9'(ROWS) : w_addr_sum;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (frame_tick) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = SEND;
      SEND:    if (col_ready) w_state_nxt = w_last ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_address <= 8'd0;
      r_col_data    <= '0;
      r_col_index   <= '0;
      r_col_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_offset      <= 8'd0;
    end else begin
      r_frame_done <= 1'b0;
      // A tick is only honoured from IDLE; anything else is flagged and dropped.
      r_overrun    <= frame_tick && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_rom_address <= r_offset;
            r_col_index   <= '0;
          end
        end
        CAPTURE: begin
          r_col_data  <= rom_data;
          r_col_valid <= 1'b1;
        end
        SEND: begin
          if (w_hs) begin
            r_col_valid <= 1'b0;
            if (!w_last) begin
              r_col_index   <= r_col_index + IDX_W'(1);
              r_rom_address <= w_addr_next[7:0];
            end else begin
              r_frame_done <= 1'b1;
              if (!pause) r_offset <= f_next_offset(r_offset, dir);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_address = r_rom_address;
  assign col_data    = r_col_data;
  assign col_index   = r_col_index;
  assign col_valid   = r_col_valid;
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;
  assign offset      = r_offset;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with a registered-address ROM model.
module tb_banner_scroll_ctrl;

  localparam int ROWS   = 129;
  localparam int WIDTH  = 57;
  localparam int WINDOW = 16;
  localparam int IDX_W  = $clog2(WINDOW);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_tick = 1'b0;
  logic             pause = 1'b0;
  logic             dir = 1'b0;
  logic [7:0]       rom_address;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] col_data;
  logic [IDX_W-1:0] col_index;
  logic             col_valid;
  logic             col_ready = 1'b1;
  logic             frame_done;
  logic             overrun;
  logic [7:0]       offset;

  int n_cmp = 0;
  int n_err = 0;
  int m_off = 0;
  int seen_idx = -1;

  banner_scroll_ctrl #(.ROWS(ROWS), .WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .dir(dir),
    .rom_address(rom_address), .rom_data(rom_data),
    .col_data(col_data), .col_index(col_index), .col_valid(col_valid),
    .col_ready(col_ready), .frame_done(frame_done), .overrun(overrun),
    .offset(offset)
  );

  always #5 clk = ~clk;

  // Row r holds r in two byte lanes above a constant 7, so row 0 reads 57'h7.
  function automatic logic [WIDTH-1:0] rowval(input int r);
    return (57'(r) << 40) | (57'(r) << 8) | 57'h7;
  endfunction

  always @(posedge clk) rom_data <= rowval(int'(rom_address));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"},  rom_address, 0);
    chk({tag, "_data"},  col_data, 0);
    chk({tag, "_index"}, col_index, 0);
    chk({tag, "_valid"}, col_valid, 0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_ovr"},   overrun, 0);
    chk({tag, "_off"},   offset, 0);
  endtask

  task automatic frame(input bit p, input bit d, input int stall_col, input int tick_col,
                       input bit tick_last, input int rst_col);
    int off0;
    int a;
    off0 = m_off;
    pause = p;
    dir = d;
    col_ready = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("start_addr", rom_address, off0);
    chk("start_valid", col_valid, 0);
    for (int k = 0; k < WINDOW; k++) begin
      step();
      if (k == tick_col) frame_tick = 1'b1;
      step();
      if (k == tick_col) begin
        frame_tick = 1'b0;
        chk("overrun_mid", overrun, 1);
      end
      a = (off0 + k) % ROWS;
      chk("valid", col_valid, 1);
      chk("index", col_index, k);
      chk("data", col_data, rowval(a));
      if (col_data == 57'h7) seen_idx = int'(col_index);
      if (k == rst_col) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("rst_mid");
        m_off = 0;
        return;
      end
      if (k == stall_col) begin
        col_ready = 1'b0;
        repeat (5) begin
          step();
          chk("stall_valid", col_valid, 1);
          chk("stall_index", col_index, k);
          chk("stall_data", col_data, rowval(a));
          chk("stall_addr", rom_address, a);
        end
        col_ready = 1'b1;
      end
      if (k == WINDOW - 1 && tick_last) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (k == tick_col) chk("overrun_clr", overrun, 0);
      chk("hs_valid", col_valid, 0);
      if (k < WINDOW - 1) begin
        chk("next_addr", rom_address, (off0 + k + 1) % ROWS);
        chk("done_low", frame_done, 0);
      end else begin
        if (!p) m_off = d ? ((m_off == 0) ? ROWS - 1 : m_off - 1)
                          : ((m_off == ROWS - 1) ? 0 : m_off + 1);
        chk("frame_done", frame_done, 1);
        chk("offset", offset, m_off);
        chk("overrun_last", overrun, tick_last);
      end
    end
    step();
    chk("done_clr", frame_done, 0);
    chk("idle_valid", col_valid, 0);
    chk("ovr_clr", overrun, 0);
    if (tick_last) begin
      repeat (3) step();
      chk("no_restart_valid", col_valid, 0);
      chk("no_restart_addr", rom_address, (off0 + WINDOW - 1) % ROWS);
    end
  endtask

  initial begin
    // Reset held two cycles with a tick that must be ignored
    rst = 1'b1;
    frame_tick = 1'b1;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    frame_tick = 1'b0;
    repeat (3) step();
    chk("post_reset_valid", col_valid, 0);
    chk("post_reset_addr", rom_address, 0);

    frame(0, 0, -1, -1, 0, -1);
    chk("basic_offset", offset, 1);

    frame(0, 0, 3, -1, 0, -1);
    chk("stall_offset", offset, 2);

    frame(0, 0, -1, 7, 0, -1);
    chk("overrun_offset", offset, 3);

    frame(1, 0, -1, -1, 1, -1);
    chk("pause_offset", offset, 3);

    frame(0, 0, -1, -1, 0, -1);
    frame(0, 0, -1, -1, 0, -1);
    chk("offset5", offset, 5);
    frame(0, 1, -1, -1, 0, -1);
    chk("dec_offset", offset, 4);

    frame(0, 0, -1, -1, 0, 10);
    frame(0, 1, -1, -1, 0, -1);
    chk("wrap_down", offset, 128);
    frame(0, 0, -1, -1, 0, -1);
    chk("wrap_up", offset, 0);

    for (int i = 0; i < 9; i++) frame(0, 1, -1, -1, 0, -1);
    chk("offset120", offset, 120);
    seen_idx = -1;
    frame(0, 0, -1, -1, 0, -1);
    chk("wrap_row0_index", seen_idx, 9);
    chk("offset121", offset, 121);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
